// File: rtl/pll_rst_seq.sv
// PLL lock qualifier and reset sequencer: synchronizes LOCK, filters glitches,
// holds downstream reset through a stabilisation window and counts lock losses.
module pll_rst_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int CNT_W              = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lock,
  input  logic             clr_cnt,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             lock_lost_pulse,
  output logic [CNT_W-1:0] lock_lost_cnt
);

  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                           LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             lock_meta, lock_s;
  logic             loss;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous LOCK input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock;
      lock_s    <= lock_meta;
    end
  end

  // The WAIT_LOCK edge that sees lock_s high already counts as the first
  // qualified cycle, so STABLE is entered with the timer at 1.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    case (state)
      WAIT_LOCK: begin
        tmr_nxt = '0;
        if (lock_s) begin
          if (LOCK_STABLE_CYCLES == 1) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = STABLE;
            tmr_nxt   = TMR_W'(1);
          end
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          tmr_nxt   = '0;
        end else if (tmr == STABLE_LAST) begin
          state_nxt = HOLD;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          tmr_nxt   = '0;
        end else if (tmr == HOLD_LAST) begin
          state_nxt = RUN;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      RUN: begin
        tmr_nxt = '0;
        if (!lock_s) state_nxt = WAIT_LOCK;
      end
      default: begin
        state_nxt = WAIT_LOCK;
        tmr_nxt   = '0;
      end
    endcase
  end

  assign loss = (state == RUN) && !lock_s;

  // Stage p2: FSM state and registered outputs, all derived from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= WAIT_LOCK;
      tmr             <= '0;
      sys_rst_n       <= 1'b0;
      ready           <= 1'b0;
      lock_lost_pulse <= 1'b0;
      lock_lost_cnt   <= '0;
    end else begin
      state           <= state_nxt;
      tmr             <= tmr_nxt;
      sys_rst_n       <= (state_nxt == RUN);
      ready           <= (state_nxt == RUN);
      lock_lost_pulse <= loss;
      if (clr_cnt)
        lock_lost_cnt <= loss ? CNT_W'(1) : '0;
      else if (loss)
        lock_lost_cnt <= sat_inc(lock_lost_cnt);
    end
  end

endmodule
